sram_fifo_param: RTL and testbench
==================================

SRAM_FIFO_PARAM -- requirements
Module: sram_fifo_param

Interface
REQ-001 Parameter BITS, default 8, data word width in bits.
REQ-002 Parameter DEPTH_LOG2, default 3; FIFO depth DEPTH = 2**DEPTH_LOG2 words.
REQ-003 Parameter AFULL_LVL, default DEPTH-1; almost-full threshold in words.
REQ-004 Parameter AEMPTY_LVL, default 1; almost-empty threshold in words.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 readMode  input  1  read request, sampled at posedge clk.
REQ-008 writeMode  input  1  write request, sampled at posedge clk.
REQ-009 inputPacket  input  BITS  write data.
REQ-010 outputPacket  output  BITS  registered read data.
REQ-011 count  output  DEPTH_LOG2+1  number of words stored, 0..DEPTH.
REQ-012 full, empty  output  1 each  count==DEPTH, count==0.
REQ-013 almostFull, almostEmpty  output  1 each  count>=AFULL_LVL, count<=AEMPTY_LVL.
REQ-014 overflow, underflow  output  1 each  sticky error flags; present only under FIFO_ERR_FLAGS_EN.
REQ-015 errClr  input  1  clears sticky error flags; present only under FIFO_ERR_FLAGS_EN.

Function
REQ-016 Storage SHALL be a DEPTH x BITS register array addressed by wrPtr and rdPtr, each DEPTH_LOG2 bits wide, wrapping from DEPTH-1 to 0.
REQ-017 Write accepted when writeMode=1 and (full=0 or read accepted in the same cycle): mem[wrPtr] <= inputPacket, wrPtr increments.
REQ-018 Read accepted when readMode=1 and empty=0: outputPacket <= mem[rdPtr] at that posedge (one-cycle latency), rdPtr increments.
REQ-019 outputPacket SHALL hold its last value when no read is accepted.
REQ-020 count: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-021 Simultaneous read+write when empty: write accepted, read rejected, count becomes 1, outputPacket unchanged.
REQ-022 Simultaneous read+write when full: both accepted, count stays DEPTH, oldest word output.
REQ-023 Write when full without read: dropped, memory and pointers unchanged.
REQ-024 Read when empty: ignored, pointers and outputPacket unchanged.
REQ-025 full, empty, almostFull, almostEmpty SHALL be combinational decodes of the count register only (no input-to-output paths).
REQ-026 Data SHALL be returned in strict write order across pointer wrap-around.

Reset
REQ-027 rst=1 SHALL immediately clear wrPtr, rdPtr, count, outputPacket (all zeros), and overflow/underflow when present; empty=1, almostEmpty=1, full=0, almostFull=0 (unless AFULL_LVL==0).
REQ-028 Memory contents SHALL NOT be cleared by reset; reset mid-operation discards all stored words.
REQ-029 First accepted operation SHALL be at the first posedge clk with rst=0.

Configuration
REQ-030 Macro FIFO_ERR_FLAGS_EN defined: overflow sets on a dropped write (REQ-023), underflow sets on an ignored read (REQ-024); both remain 1 until errClr=1 at a posedge or rst; set wins over errClr in the same cycle.
REQ-031 FIFO_ERR_FLAGS_EN undefined: overflow, underflow, errClr ports and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 BITS=8, DEPTH_LOG2=3: reset, write FF for 8 cycles -> full=1, count=8; read 8 cycles -> outputPacket=FF each read, empty=1, count=0.
REQ-033 Write 01..0C with reads interleaved to force wrap -> reads return 01..0C in order, no loss.
REQ-034 Full FIFO, write+read same cycle with inputPacket=AA -> count stays 8, AA read out eighth after the oldest.
REQ-035 Empty FIFO, readMode=1 for 2 cycles -> outputPacket unchanged, count=0; with FIFO_ERR_FLAGS_EN underflow=1 until errClr pulse.
REQ-036 Count 5, rst asserted mid-cycle -> count, pointers, outputPacket 0 before next posedge; almostFull/almostEmpty track count at thresholds 7 and 1.

Source files
------------

// File: rtl/sram_fifo_param.sv
// Single-clock FIFO on a register array with registered read data and count-decoded status flags.
// Optional sticky overflow/underflow flags with errClr are compiled in when FIFO_ERR_FLAGS_EN is defined.
module sram_fifo_param #(
    parameter int BITS       = 8,
    parameter int DEPTH_LOG2 = 3,
    parameter int AFULL_LVL  = (2**DEPTH_LOG2) - 1,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  readMode,
    input  logic                  writeMode,
    input  logic [BITS-1:0]       inputPacket,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic                  errClr,
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [BITS-1:0]       outputPacket,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almostFull,
    output logic                  almostEmpty
);

    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AFULL_C  = (DEPTH_LOG2+1)'(AFULL_LVL);
    localparam logic [DEPTH_LOG2:0] AEMPTY_C = (DEPTH_LOG2+1)'(AEMPTY_LVL);

    logic [BITS-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic                  rdAcc;
    logic                  wrAcc;

    // Status comes only from the count register, so no input reaches a flag combinationally.
    assign full        = (count == DEPTH_C);
    assign empty       = (count == '0);
    assign almostFull  = (count >= AFULL_C);
    assign almostEmpty = (count <= AEMPTY_C);

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rdAcc = readMode && !empty;
    assign wrAcc = writeMode && (!full || rdAcc);

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (wrAcc)
            mem[wrPtr] <= inputPacket;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            count        <= '0;
            outputPacket <= '0;
        end else begin
            if (wrAcc)
                wrPtr <= wrPtr + 1'b1;
            if (rdAcc) begin
                rdPtr        <= rdPtr + 1'b1;
                outputPacket <= mem[rdPtr];
            end
            case ({wrAcc, rdAcc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // A new error event in the same cycle as errClr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (writeMode && !wrAcc)
                overflow <= 1'b1;
            else if (errClr)
                overflow <= 1'b0;
            if (readMode && empty)
                underflow <= 1'b1;
            else if (errClr)
                underflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sram_fifo_param.sv
// Directed bench for sram_fifo_param at BITS=8, DEPTH_LOG2=3.
// Exercises fill/drain, wrap ordering, full read+write, empty reads and mid-cycle reset.
module tb_sram_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       readMode;
    logic       writeMode;
    logic [7:0] inputPacket;
    logic [7:0] outputPacket;
    logic [3:0] count;
    logic       full, empty, almostFull, almostEmpty;
`ifdef FIFO_ERR_FLAGS_EN
    logic       errClr;
    logic       overflow, underflow;
`endif

    int checks = 0;
    int errors = 0;

    sram_fifo_param #(.BITS(8), .DEPTH_LOG2(3)) dut (
        .clk(clk),
        .rst(rst),
        .readMode(readMode),
        .writeMode(writeMode),
        .inputPacket(inputPacket),
`ifdef FIFO_ERR_FLAGS_EN
        .errClr(errClr),
        .overflow(overflow),
        .underflow(underflow),
`endif
        .outputPacket(outputPacket),
        .count(count),
        .full(full),
        .empty(empty),
        .almostFull(almostFull),
        .almostEmpty(almostEmpty)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        readMode    = 1'b0;
        writeMode   = 1'b0;
        inputPacket = 8'h00;
`ifdef FIFO_ERR_FLAGS_EN
        errClr      = 1'b0;
`endif
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #2;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (outputPacket !== 8'h00) begin errors++; $display("FAIL reset_out got=%h exp=00", outputPacket); end
        checks++; if ({full, empty, almostFull, almostEmpty} !== 4'b0101) begin errors++;
            $display("FAIL reset_flags got=%b exp=0101", {full, empty, almostFull, almostEmpty}); end
`ifdef FIFO_ERR_FLAGS_EN
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", {overflow, underflow}); end
`endif
        tick();
        rst = 1'b0;
    endtask

    task automatic test_fill_drain();
        writeMode   = 1'b1;
        inputPacket = 8'hFF;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++; if (count !== 4'(i)) begin errors++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i); end
            checks++; if (almostFull !== (i >= 7)) begin errors++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, almostFull, (i >= 7)); end
            checks++; if (almostEmpty !== (i <= 1)) begin errors++; $display("FAIL fill_aempty i=%0d got=%b exp=%b", i, almostEmpty, (i <= 1)); end
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
        writeMode = 1'b0;
        readMode  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++; if (outputPacket !== 8'hFF) begin errors++; $display("FAIL drain_data i=%0d got=%h exp=ff", i, outputPacket); end
            checks++; if (count !== 4'(8 - i)) begin errors++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, count, 8 - i); end
        end
        idle();
        checks++; if ({full, empty} !== 2'b01) begin errors++; $display("FAIL drain_flags got=%b exp=01", {full, empty}); end
    endtask

    task automatic test_wrap();
        // Six writes, six read+write pairs, six reads: wrPtr passes 7->0 mid-stream.
        writeMode = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            inputPacket = 8'(i);
            tick();
        end
        checks++; if (count !== 4'd6) begin errors++; $display("FAIL wrap_count6 got=%0d exp=6", count); end
        readMode = 1'b1;
        for (int i = 7; i <= 12; i++) begin
            inputPacket = 8'(i);
            tick();
            checks++; if (outputPacket !== 8'(i - 6)) begin errors++; $display("FAIL wrap_rw i=%0d got=%h exp=%h", i, outputPacket, 8'(i - 6)); end
            checks++; if (count !== 4'd6) begin errors++; $display("FAIL wrap_rw_count got=%0d exp=6", count); end
        end
        writeMode = 1'b0;
        for (int i = 7; i <= 12; i++) begin
            tick();
            checks++; if (outputPacket !== 8'(i)) begin errors++; $display("FAIL wrap_rd got=%h exp=%h", outputPacket, 8'(i)); end
        end
        idle();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", empty); end
    endtask

    task automatic test_full_rw();
        logic [7:0] expq [8];
        expq = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'hAA};
        writeMode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            inputPacket = 8'h20 + 8'(i);
            tick();
        end
        // Dropped write must not disturb contents.
        inputPacket = 8'h99;
        tick();
        checks++; if ({full, count} !== {1'b1, 4'd8}) begin errors++; $display("FAIL ovf_count got=%0d exp=8", count); end
`ifdef FIFO_ERR_FLAGS_EN
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        writeMode = 1'b0;
        errClr    = 1'b1;
        tick();
        errClr    = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
        writeMode = 1'b1;
`endif
        readMode    = 1'b1;
        inputPacket = 8'hAA;
        tick();
        checks++; if (outputPacket !== 8'h20) begin errors++; $display("FAIL full_rw_data got=%h exp=20", outputPacket); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_rw_count got=%0d exp=8", count); end
        writeMode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (outputPacket !== expq[i]) begin errors++; $display("FAIL full_rw_rd i=%0d got=%h exp=%h", i, outputPacket, expq[i]); end
        end
        idle();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL full_rw_end got=%0d exp=0", count); end
    endtask

    task automatic test_empty_read();
        // outputPacket currently holds AA from the previous drain.
        readMode = 1'b1;
        repeat (2) begin
            tick();
            checks++; if (outputPacket !== 8'hAA) begin errors++; $display("FAIL udf_hold got=%h exp=aa", outputPacket); end
            checks++; if (count !== 4'd0) begin errors++; $display("FAIL udf_count got=%0d exp=0", count); end
        end
`ifdef FIFO_ERR_FLAGS_EN
        readMode = 1'b0;
        tick();
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_sticky got=%b exp=1", underflow); end
        errClr = 1'b1;
        tick();
        errClr = 1'b0;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf_clr got=%b exp=0", underflow); end
        readMode = 1'b1;
`endif
        writeMode   = 1'b1;
        inputPacket = 8'h3C;
        tick();
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL empty_rw_count got=%0d exp=1", count); end
        checks++; if (outputPacket !== 8'hAA) begin errors++; $display("FAIL empty_rw_out got=%h exp=aa", outputPacket); end
        writeMode = 1'b0;
        tick();
        checks++; if (outputPacket !== 8'h3C) begin errors++; $display("FAIL empty_rw_rd got=%h exp=3c", outputPacket); end
        idle();
    endtask

    task automatic test_reset_mid();
        writeMode = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            inputPacket = 8'h40 + 8'(i);
            tick();
        end
        idle();
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL mid_count5 got=%0d exp=5", count); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
        checks++; if (outputPacket !== 8'h00) begin errors++; $display("FAIL mid_rst_out got=%h exp=00", outputPacket); end
        checks++; if ({full, empty, almostFull, almostEmpty} !== 4'b0101) begin errors++;
            $display("FAIL mid_rst_flags got=%b exp=0101", {full, empty, almostFull, almostEmpty}); end
        #1;
        rst = 1'b0;
        // Old words are gone: next read returns the first post-reset write.
        writeMode   = 1'b1;
        inputPacket = 8'h5A;
        tick();
        writeMode = 1'b0;
        readMode  = 1'b1;
        tick();
        idle();
        checks++; if (outputPacket !== 8'h5A) begin errors++; $display("FAIL mid_post_rd got=%h exp=5a", outputPacket); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_post_empty got=%b exp=1", empty); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_rw();
        test_empty_read();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
